layer_three_dense: RTL and testbench

LAYER_THREE_DENSE -- requirements
Module: layer_three_dense

---
 rtl/layer_three_dense_pkg.sv | 47 ++++
 rtl/layer_three_dense_popcount49.sv | 27 ++
 rtl/layer_three_dense.sv | 162 ++++++++++++++++
 tb/tb_layer_three_dense.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/layer_three_dense_pkg.sv
// -----------------------------------------------------------------------------
// layer_three_dense_pkg
// Shared definitions for the binary dense output layer:
//   - top-level sequencer state encodings (S_LAYER_2, S_LAYER_3)
//   - layer geometry (N_FEAT, N_CLASS, CHUNK, SCORE_W)
//   - FSM state type for the dense-layer controller
//   - helpers that compute the bit offsets of a chunk inside the
//     feature and weight vectors
// -----------------------------------------------------------------------------
package layer_three_dense_pkg;

  // Top-level sequencer states seen on the `state` input
  localparam logic [2:0] S_LAYER_2 = 3'b011;
  localparam logic [2:0] S_LAYER_3 = 3'b100;

  // Layer geometry
  localparam int N_FEAT  = 196;
  localparam int N_CLASS = 10;
  localparam int CHUNK   = 49;
  localparam int SCORE_W = 8;

  // Counter and term widths
  localparam int CLASS_W = 4;
  localparam int CHUNK_W = 2;
  localparam int TERM_W  = 6;

  localparam logic [CLASS_W-1:0] LAST_CLASS = 4'd9;
  localparam logic [CHUNK_W-1:0] LAST_CHUNK = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } fsm_t;

  // Offset of chunk `chk` inside the 196-bit feature map
  function automatic logic [7:0] feat_base(input logic [CHUNK_W-1:0] chk);
    return {6'd0, chk} * 8'd49;
  endfunction

  // Offset of chunk `chk` of class `cls` inside the 1960-bit weight vector
  function automatic logic [10:0] weight_base(input logic [CLASS_W-1:0] cls,
                                              input logic [CHUNK_W-1:0] chk);
    return ({7'd0, cls} * 11'd196) + ({9'd0, chk} * 11'd49);
  endfunction

endpackage

// File: rtl/layer_three_dense_popcount49.sv
// -----------------------------------------------------------------------------
// popcount49
// Purely combinational population count of a 49-bit vector.
// Ports:
//   bits  [48:0] in  - vector to count
//   count [5:0]  out - number of ones in `bits` (0..49)
// -----------------------------------------------------------------------------
module popcount49
  import layer_three_dense_pkg::*;
(
  input  logic [CHUNK-1:0]  bits,
  output logic [TERM_W-1:0] count
);

  logic [TERM_W-1:0] count_s;

  // Ripple sum of the individual bits; the tool is free to rebalance it
  always_comb begin
    count_s = 6'd0;
    for (int i = 0; i < CHUNK; i++) begin
      count_s = count_s + {5'd0, bits[i]};
    end
  end

  assign count = count_s;

endmodule

// File: rtl/layer_three_dense.sv
// -----------------------------------------------------------------------------
// layer_three_dense
// Binary (XNOR-popcount) fully connected output layer with argmax.
// Processes one 49-bit chunk per qualifying clock edge: 4 chunks per class,
// 10 classes, so the result is ready 41 qualifying edges after start.
// Ports:
//   clk       in   clock, all registers on the rising edge
//   rst       in   synchronous active-high reset
//   state [2:0]      in   top-level sequencer state; runs only in S_LAYER_3
//   features [195:0] in   layer-two binary map (filter*49 + row*7 + col)
//   weights [1959:0] in   dense weights, class k at [k*196 +: 196]
//   scores [79:0]    out  per-class score, class k at [k*8 +: 8]
//   digit [3:0]      out  argmax class (lowest index wins ties)
//   done             out  result valid, sticky until reset
// -----------------------------------------------------------------------------
module layer_three_dense
  import layer_three_dense_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   state,
  input  logic [N_FEAT-1:0]            features,
  input  logic [N_FEAT*N_CLASS-1:0]    weights,
  output logic [SCORE_W*N_CLASS-1:0]   scores,
  output logic [CLASS_W-1:0]           digit,
  output logic                         done
);

  fsm_t                        fsm_r;
  fsm_t                        fsm_next_s;
  logic [CLASS_W-1:0]          class_r;
  logic [CHUNK_W-1:0]          chunk_r;
  logic [SCORE_W-1:0]          acc_r;
  logic [SCORE_W-1:0]          best_r;
  logic [SCORE_W*N_CLASS-1:0]  scores_r;
  logic [CLASS_W-1:0]          digit_r;
  logic                        done_r;

  logic                        run_s;
  logic                        last_chunk_s;
  logic                        last_class_s;
  logic [7:0]                  feat_base_s;
  logic [10:0]                 weight_base_s;
  logic [CHUNK-1:0]            feat_chunk_s;
  logic [CHUNK-1:0]            weight_chunk_s;
  logic [CHUNK-1:0]            xnor_s;
  logic [TERM_W-1:0]           term_s;
  logic [SCORE_W-1:0]          total_s;

  assign run_s        = (state == S_LAYER_3);
  assign last_chunk_s = (chunk_r == LAST_CHUNK);
  assign last_class_s = (class_r == LAST_CLASS);

  // Select the current chunk of features and of the current class' weights
  always_comb begin
    feat_base_s    = feat_base(chunk_r);
    weight_base_s  = weight_base(class_r, chunk_r);
    feat_chunk_s   = features[feat_base_s +: CHUNK];
    weight_chunk_s = weights[weight_base_s +: CHUNK];
    xnor_s         = ~(feat_chunk_s ^ weight_chunk_s);
  end

  popcount49 u_popcount49 (
    .bits  (xnor_s),
    .count (term_s)
  );

  // Running class total including this chunk; max 196 fits in 8 bits
  assign total_s = acc_r + {2'd0, term_s};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r <= IDLE;
    end else begin
      fsm_r <= fsm_next_s;
    end
  end

  // FSM next-state logic; pauses whenever the sequencer leaves S_LAYER_3
  always_comb begin
    fsm_next_s = fsm_r;
    case (fsm_r)
      IDLE: begin
        if (run_s) begin
          fsm_next_s = ACCUM;
        end else begin
          fsm_next_s = IDLE;
        end
      end
      ACCUM: begin
        if (run_s && last_chunk_s && last_class_s) begin
          fsm_next_s = DONE;
        end else begin
          fsm_next_s = ACCUM;
        end
      end
      DONE: begin
        fsm_next_s = DONE;
      end
      default: begin
        fsm_next_s = IDLE;
      end
    endcase
  end

  // Counters, accumulator, argmax comparator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      class_r  <= 4'd0;
      chunk_r  <= 2'd0;
      acc_r    <= 8'd0;
      best_r   <= 8'd0;
      scores_r <= 80'd0;
      digit_r  <= 4'd0;
      done_r   <= 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (run_s) begin
            class_r <= 4'd0;
            chunk_r <= 2'd0;
            acc_r   <= 8'd0;
            best_r  <= 8'd0;
          end
        end
        ACCUM: begin
          if (run_s) begin
            if (last_chunk_s) begin
              scores_r[{class_r, 3'b000} +: SCORE_W] <= total_s;
              acc_r   <= 8'd0;
              chunk_r <= 2'd0;
              class_r <= class_r + 4'd1;
              // Strictly greater: on a tie the earlier (lower) class stays
              if (total_s > best_r) begin
                best_r  <= total_s;
                digit_r <= class_r;
              end
              if (last_class_s) begin
                done_r <= 1'b1;
              end
            end else begin
              acc_r   <= total_s;
              chunk_r <= chunk_r + 2'd1;
            end
          end
        end
        DONE: begin
          done_r <= 1'b1;
        end
        default: begin
          done_r <= done_r;
        end
      endcase
    end
  end

  assign scores = scores_r;
  assign digit  = digit_r;
  assign done   = done_r;

endmodule

// File: tb/tb_layer_three_dense.sv
// -----------------------------------------------------------------------------
// tb_layer_three_dense
// Directed bench for layer_three_dense. Expected results come from a
// bit-serial XNOR model, are queued when a run starts and are popped and
// compared when the DUT raises done.
// -----------------------------------------------------------------------------
module tb_layer_three_dense;
  import layer_three_dense_pkg::*;

  logic          clk;
  logic          rst;
  logic [2:0]    state;
  logic [195:0]  features;
  logic [1959:0] weights;
  logic [79:0]   scores;
  logic [3:0]    digit;
  logic          done;

  typedef struct {
    logic [79:0] scores;
    logic [3:0]  digit;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  layer_three_dense dut (
    .clk      (clk),
    .rst      (rst),
    .state    (state),
    .features (features),
    .weights  (weights),
    .scores   (scores),
    .digit    (digit),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] model_scores(input logic [195:0] f, input logic [1959:0] w);
    logic [79:0] s;
    int cnt;
    s = '0;
    for (int k = 0; k < 10; k++) begin
      cnt = 0;
      for (int i = 0; i < 196; i++) begin
        if (f[i] == w[k*196 + i]) cnt++;
      end
      s[k*8 +: 8] = cnt[7:0];
    end
    return s;
  endfunction

  function automatic logic [3:0] model_digit(input logic [79:0] s);
    logic [7:0] best;
    logic [3:0] d;
    best = 8'd0;
    d    = 4'd0;
    for (int k = 0; k < 10; k++) begin
      if (s[k*8 +: 8] > best) begin
        best = s[k*8 +: 8];
        d    = 4'(k);
      end
    end
    return d;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    state = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One full run from IDLE; optional pause on edges 21..25
  task automatic run_case(input string tag, input logic [195:0] f,
                          input logic [1959:0] w, input bit pause);
    exp_t e;
    int   done_edge;
    features = f;
    weights  = w;
    e.scores = model_scores(f, w);
    e.digit  = model_digit(e.scores);
    e.lat    = pause ? 46 : 41;
    sb.push_back(e);
    done_edge = 0;
    for (int ei = 1; ei <= 100 && done_edge == 0; ei++) begin
      @(negedge clk);
      state = (pause && ei >= 21 && ei <= 25) ? 3'b000 : S_LAYER_3;
      @(posedge clk);
      #1;
      if (done) done_edge = ei;
    end
    e = sb.pop_front();
    check({tag, "_done_edge"}, 80'(done_edge), 80'(e.lat));
    check({tag, "_scores"}, scores, e.scores);
    check({tag, "_digit"}, 80'(digit), 80'(e.digit));
    // Outputs must hold in DONE whatever the sequencer does
    @(negedge clk);
    state = 3'b000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    state = S_LAYER_3;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_hold_done"}, 80'(done), 80'd1);
    check({tag, "_hold_scores"}, scores, e.scores);
    check({tag, "_hold_digit"}, 80'(digit), 80'(e.digit));
  endtask

  initial begin
    logic [195:0]  ones_f;
    logic [195:0]  f;
    logic [1959:0] w;
    logic [1959:0] w_rand;
    logic [195:0]  f_rand;

    rst      = 1'b1;
    state    = 3'b000;
    features = '0;
    weights  = '0;
    ones_f   = '1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_scores", scores, 80'd0);
    check("reset_digit", 80'(digit), 80'd0);
    check("reset_done", 80'(done), 80'd0);
    @(negedge clk);
    rst = 1'b0;

    // All-zero inputs: every class scores 196, digit 0
    run_case("all_zero", '0, '0, 1'b0);
    check("all_zero_score0", 80'(scores[7:0]), 80'd196);

    // Single-class match on class 7
    do_reset();
    w = '0;
    w[7*196 +: 196] = ones_f;
    run_case("class7", ones_f, w, 1'b0);
    check("class7_digit_const", 80'(digit), 80'd7);

    // Tie between classes 3 and 8 keeps the lower index
    do_reset();
    w = '0;
    w[3*196 +: 196] = ones_f;
    w[8*196 +: 196] = ones_f;
    run_case("tie", ones_f, w, 1'b0);
    check("tie_digit_const", 80'(digit), 80'd3);

    // Chunk indexing: only the last chunk of class 5 matches
    do_reset();
    w = '0;
    for (int i = 147; i < 196; i++) w[5*196 + i] = 1'b1;
    run_case("chunk3", ones_f, w, 1'b0);
    check("chunk3_score5", 80'(scores[47:40]), 80'd49);
    check("chunk3_digit_const", 80'(digit), 80'd5);

    // Random data, unpaused then paused: same results, 5 edges later
    for (int i = 0; i < 196; i++) f_rand[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < 1960; i++) w_rand[i] = 1'($urandom_range(0, 1));
    do_reset();
    run_case("rand_nopause", f_rand, w_rand, 1'b0);
    do_reset();
    run_case("rand_pause", f_rand, w_rand, 1'b1);

    // Reset in the middle of accumulation
    do_reset();
    f = ~f_rand;
    features = f;
    weights  = w_rand;
    for (int ei = 1; ei <= 15; ei++) begin
      @(negedge clk);
      state = S_LAYER_3;
      if (ei == 15) rst = 1'b1;
      @(posedge clk);
    end
    #1;
    check("midrst_scores", scores, 80'd0);
    check("midrst_digit", 80'(digit), 80'd0);
    check("midrst_done", 80'(done), 80'd0);
    @(negedge clk);
    rst   = 1'b0;
    state = 3'b000;
    run_case("midrst_rerun", f, w_rand, 1'b0);

    // Reset while in DONE clears everything
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("donerst_done", 80'(done), 80'd0);
    check("donerst_scores", scores, 80'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
